// File: rtl/if_id_pkg.sv
// if_id_pkg: opcode constants and field positions shared by the IF/ID queue.
package if_id_pkg;
    localparam logic [3:0]  OP_HLT    = 4'hF;
    localparam logic [3:0]  OP_BR_REG = 4'hD;
    localparam logic [2:0]  BR_PREFIX = 3'b110;
    localparam logic [15:0] NOP       = 16'h0000;
    localparam int FIELD_W = 4;
    localparam int RT_LSB  = 0;
    localparam int RS_LSB  = 4;
    localparam int RD_LSB  = 8;
    localparam int OP_LSB  = 12;
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: generic DEPTH-entry FIFO with count and synchronous clear; caller guards push/pop.
module instr_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    // storage carries no reset; count alone decides what is valid
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wptr] <= wdata;
    end
    assign rdata = mem[rptr];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry instruction/PC queue between fetch and decode,
// with flush, sticky halt and head pre-decode.
module if_id_queue
    import if_id_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int PC_W    = 16,
    parameter int INSTR_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_valid,
    output logic                   if_ready,
    input  logic [INSTR_W-1:0]     if_instr,
    input  logic [PC_W-1:0]        if_pc,
    input  logic                   flush,
    input  logic                   id_ready,
    output logic                   id_valid,
    output logic [INSTR_W-1:0]     id_instr,
    output logic [PC_W-1:0]        id_pc,
    output logic [3:0]             id_rs,
    output logic [3:0]             id_rt,
    output logic [3:0]             id_rd,
    output logic                   id_branch,
    output logic                   id_branch_reg,
    output logic                   id_hlt,
    output logic [$clog2(DEPTH):0] count
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [INSTR_W+PC_W-1:0] rdata;
    logic                    halted, push, pop;
    assign if_ready = (count != CW'(DEPTH)) && !halted;
    assign id_valid = count != '0;
    assign push     = if_valid && if_ready;
    assign pop      = id_valid && id_ready;
    instr_fifo #(.DEPTH(DEPTH), .W(INSTR_W + PC_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({if_instr, if_pc}),
        .rdata (rdata),
        .count (count)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) halted <= 1'b0;
        else if (flush) halted <= 1'b0;
        else if (push && if_instr[OP_LSB +: FIELD_W] == OP_HLT) halted <= 1'b1;
    end
    // empty queue presents a NOP bubble so decode flags stay quiet
    assign id_instr      = id_valid ? rdata[PC_W +: INSTR_W] : NOP;
    assign id_pc         = id_valid ? rdata[PC_W-1:0] : '0;
    assign id_rs         = id_instr[RS_LSB +: FIELD_W];
    assign id_rt         = id_instr[RT_LSB +: FIELD_W];
    assign id_rd         = id_instr[RD_LSB +: FIELD_W];
    assign id_branch     = id_instr[OP_LSB+1 +: 3] == BR_PREFIX;
    assign id_branch_reg = id_instr[OP_LSB +: FIELD_W] == OP_BR_REG;
    assign id_hlt        = id_instr[OP_LSB +: FIELD_W] == OP_HLT;
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed plus random stimulus against a queue-based reference model.
module tb_if_id_queue;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;
    logic          clk, rst_n;
    logic          if_valid, if_ready, flush, id_ready, id_valid;
    logic [15:0]   if_instr, if_pc, id_instr, id_pc;
    logic [3:0]    id_rs, id_rt, id_rd;
    logic          id_branch, id_branch_reg, id_hlt;
    logic [CW-1:0] count;
    int            errors = 0;
    int            checks = 0;
    logic [31:0]   q[$];
    logic          halted;

    if_id_queue #(.DEPTH(DEPTH), .PC_W(16), .INSTR_W(16)) dut (
        .clk(clk), .rst(rst_n), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .flush(flush), .id_ready(id_ready),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_rs(id_rs),
        .id_rt(id_rt), .id_rd(id_rd), .id_branch(id_branch),
        .id_branch_reg(id_branch_reg), .id_hlt(id_hlt), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [31:0] head;
        logic [15:0] hi;
        head = (q.size() != 0) ? q[0] : 32'h0;
        hi   = head[31:16];
        check("id_valid", id_valid, q.size() != 0);
        check("id_instr", id_instr, hi);
        check("id_pc", id_pc, head[15:0]);
        check("id_rs", id_rs, hi[7:4]);
        check("id_rt", id_rt, hi[3:0]);
        check("id_rd", id_rd, hi[11:8]);
        check("id_branch", id_branch, hi[15:13] == 3'b110);
        check("id_branch_reg", id_branch_reg, hi[15:12] == 4'hD);
        check("id_hlt", id_hlt, hi[15:12] == 4'hF);
        check("count", count, q.size());
        check("if_ready", if_ready, q.size() != DEPTH && !halted);
    endtask

    // called at a falling edge; returns at the next falling edge
    task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                        input logic idr, input logic fl);
        logic do_push, do_pop;
        if_valid = v; if_instr = ins; if_pc = pc; id_ready = idr; flush = fl;
        #1;
        check_model();
        do_push = v && q.size() != DEPTH && !halted;
        do_pop  = idr && q.size() != 0;
        @(posedge clk);
        if (fl) begin
            q.delete();
            halted = 1'b0;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back({ins, pc});
                if (ins[15:12] == 4'hF) halted = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1; if_valid = 0; if_instr = 0; if_pc = 0; id_ready = 0; flush = 0;
        halted = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_if_ready", if_ready, 1);
        check("rst_count", count, 0);
        step(1, 16'h1234, 16'h0010, 0, 0);
        check("t1_instr", id_instr, 16'h1234);
        check("t1_rd", id_rd, 2);
        check("t1_rs", id_rs, 3);
        check("t1_rt", id_rt, 4);
        check("t1_pc", id_pc, 16'h0010);
        step(1, 16'h2222, 16'h0012, 0, 0);
        check("full_count", count, 2);
        check("full_ready", if_ready, 0);
        step(1, 16'h3333, 16'h0014, 0, 0);
        step(1, 16'h3333, 16'h0014, 1, 0);
        check("pop_a_next_b", id_instr, 16'h2222);
        check("full_pop_no_push", count, 1);
        step(0, 16'h0, 16'h0, 1, 0);
        check("empty_after_b", id_valid, 0);
        step(0, 16'h0, 16'h0, 1, 0);
        step(1, 16'h0101, 16'h0020, 0, 0);
        step(1, 16'h0202, 16'h0022, 1, 0);
        check("pushpop_count", count, 1);
        check("pushpop_head", id_instr, 16'h0202);
        step(1, 16'h0303, 16'h0024, 0, 0);
        step(1, 16'hC005, 16'h0026, 0, 1);
        check("flush_count", count, 0);
        check("flush_instr", id_instr, 16'h0000);
        step(0, 16'h0, 16'h0, 0, 0);
        step(1, 16'hF000, 16'h0030, 0, 0);
        check("hlt_head", id_hlt, 1);
        check("hlt_ready", if_ready, 0);
        step(1, 16'h4444, 16'h0032, 1, 0);
        check("hlt_empty_ready", if_ready, 0);
        step(0, 16'h0, 16'h0, 0, 1);
        check("flush_unhalt", if_ready, 1);
        step(1, 16'hD120, 16'h0040, 0, 0);
        check("br_branch", id_branch, 1);
        check("br_reg", id_branch_reg, 1);
        if_valid = 0; id_ready = 0; flush = 0;
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", id_valid, 0);
        check("async_instr", id_instr, 0);
        check("async_branch", id_branch, 0);
        q.delete();
        halted = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_count", count, 0);
        for (int i = 0; i < 400; i++) begin
            logic [15:0] ins;
            ins = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ins[15:12] = 4'hF;
            else if ($urandom_range(0, 7) == 0) ins[15:12] = 4'hD;
            step(1'($urandom_range(0, 1)), ins, 16'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 15) == 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
